// File: rtl/ffstdp_pkg.sv
// ffstdp_pkg: shared defaults, FSM encoding and SRAM word layout for the FF-STDP weight-update path
package ffstdp_pkg;
    localparam int WEIGHT_WIDTH_DEF = 8;
    localparam int GRAD_WIDTH_DEF   = 8;
    localparam int UPD_LAT_DEF      = 2;

    typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, FIN} state_t;

    // SRAM word is {GRAD, WSYN}: weight in the low field, gradient directly above it
    localparam int WSYN_OFS = 0;

    function automatic int grad_ofs(input int weight_width);
        return WSYN_OFS + weight_width;
    endfunction

    // index width that stays legal for a count of 1
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/ffstdp_rmw_sequencer_if.sv
// ffstdp_rmw_sequencer_if: control, synapse SRAM and update-unit signals of the weight-update sequencer
interface ffstdp_rmw_sequencer_if #(
    parameter int ADDR_WIDTH   = 8,
    parameter int PRE_W        = 4,
    parameter int POST_W       = 4,
    parameter int WEIGHT_WIDTH = 8,
    parameter int GRAD_WIDTH   = 8
);
    logic                                START;
    logic                                IS_TRAIN;
    logic                                BUSY;
    logic                                DONE;
    logic [ADDR_WIDTH-1:0]               SRAM_RADDR;
    logic                                SRAM_RE;
    logic [ADDR_WIDTH-1:0]               SRAM_WADDR;
    logic                                SRAM_WE;
    logic [WEIGHT_WIDTH+GRAD_WIDTH-1:0]  SRAM_WDATA;
    logic [PRE_W-1:0]                    PRE_IDX;
    logic [POST_W-1:0]                   POST_IDX;
    logic                                UPD_EN;
    logic [WEIGHT_WIDTH-1:0]             WSYN_NEW;
    logic [GRAD_WIDTH-1:0]               GRAD_NEW;

    modport master (
        input  START, IS_TRAIN, WSYN_NEW, GRAD_NEW,
        output BUSY, DONE, SRAM_RADDR, SRAM_RE, SRAM_WADDR, SRAM_WE, SRAM_WDATA,
               PRE_IDX, POST_IDX, UPD_EN
    );

    modport slave (
        output START, IS_TRAIN, WSYN_NEW, GRAD_NEW,
        input  BUSY, DONE, SRAM_RADDR, SRAM_RE, SRAM_WADDR, SRAM_WE, SRAM_WDATA,
               PRE_IDX, POST_IDX, UPD_EN
    );
endinterface

// File: rtl/ffstdp_wb_delay.sv
// ffstdp_wb_delay: valid+address shift register that lines each read up with its write-back slot
module ffstdp_wb_delay #(
    parameter int DEPTH = 2,
    parameter int AW    = 8
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          in_valid,
    input  logic [AW-1:0] in_addr,
    output logic          out_valid,
    output logic [AW-1:0] out_addr
);
    logic [DEPTH-1:0] vld;
    logic [AW-1:0]    adr [DEPTH];

    // shift every issued read one stage per cycle; reset flushes all in-flight entries
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            vld <= '0;
            for (int i = 0; i < DEPTH; i++) adr[i] <= '0;
        end else begin
            vld[0] <= in_valid;
            adr[0] <= in_addr;
            for (int i = 1; i < DEPTH; i++) begin
                vld[i] <= vld[i-1];
                adr[i] <= adr[i-1];
            end
        end
    end

    assign out_valid = vld[DEPTH-1];
    assign out_addr  = adr[DEPTH-1];
endmodule

// File: rtl/ffstdp_rmw_sequencer.sv
// ffstdp_rmw_sequencer: sweeps every synapse on a training event, reads it and writes back the updated weight/gradient
module ffstdp_rmw_sequencer
    import ffstdp_pkg::*;
#(
    parameter int PRE_NUM      = 16,
    parameter int POST_NUM     = 16,
    parameter int WEIGHT_WIDTH = WEIGHT_WIDTH_DEF,
    parameter int GRAD_WIDTH   = GRAD_WIDTH_DEF,
    parameter int UPD_LAT      = UPD_LAT_DEF,
    parameter int ADDR_WIDTH   = idx_w(PRE_NUM * POST_NUM)
) (
    input  logic CLK,
    input  logic RST_N,
    ffstdp_rmw_sequencer_if.master bus
);
    localparam int PRE_W  = idx_w(PRE_NUM);
    localparam int POST_W = idx_w(POST_NUM);
    localparam int DCNT_W = idx_w(UPD_LAT);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(PRE_NUM * POST_NUM - 1);
    localparam logic [POST_W-1:0]     LAST_POST  = POST_W'(POST_NUM - 1);
    localparam logic [DCNT_W-1:0]     LAST_DRAIN = DCNT_W'(UPD_LAT - 1);

    state_t                state;
    logic                  busy;
    logic                  done;
    logic                  re;
    logic [ADDR_WIDTH-1:0] raddr;
    logic [PRE_W-1:0]      pre;
    logic [POST_W-1:0]     post;
    logic [DCNT_W-1:0]     dcnt;
    logic                  we;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [WEIGHT_WIDTH+GRAD_WIDTH-1:0] wdata;

    // sweep FSM: address is a running counter, pre/post indices advance alongside it
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            re    <= 1'b0;
            raddr <= '0;
            pre   <= '0;
            post  <= '0;
            dcnt  <= '0;
        end else begin
            case (state)
                IDLE: if (bus.START) begin
                    busy <= 1'b1;
                    if (bus.IS_TRAIN) begin
                        state <= SWEEP;
                        re    <= 1'b1;
                        raddr <= '0;
                        pre   <= '0;
                        post  <= '0;
                    end else begin
                        state <= FIN;
                        done  <= 1'b1;
                    end
                end
                SWEEP: if (raddr == LAST_ADDR) begin
                    state <= DRAIN;
                    re    <= 1'b0;
                    dcnt  <= '0;
                end else begin
                    raddr <= raddr + 1'b1;
                    post  <= (post == LAST_POST) ? '0 : post + 1'b1;
                    if (post == LAST_POST) pre <= pre + 1'b1;
                end
                DRAIN: if (dcnt == LAST_DRAIN) begin
                    state <= FIN;
                    done  <= 1'b1;
                end else begin
                    dcnt <= dcnt + 1'b1;
                end
                FIN: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    ffstdp_wb_delay #(.DEPTH(UPD_LAT), .AW(ADDR_WIDTH)) u_wb_delay (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .in_valid  (re),
        .in_addr   (raddr),
        .out_valid (we),
        .out_addr  (waddr)
    );

    // pack the update unit's result into the SRAM word only while a write-back is live
    always_comb begin
        wdata = '0;
        if (we) begin
            wdata[WSYN_OFS +: WEIGHT_WIDTH]           = bus.WSYN_NEW;
            wdata[grad_ofs(WEIGHT_WIDTH) +: GRAD_WIDTH] = bus.GRAD_NEW;
        end
    end

    assign bus.BUSY       = busy;
    assign bus.DONE       = done;
    assign bus.SRAM_RE    = re;
    assign bus.SRAM_RADDR = raddr;
    assign bus.PRE_IDX    = pre;
    assign bus.POST_IDX   = post;
    assign bus.SRAM_WE    = we;
    assign bus.UPD_EN     = we;
    assign bus.SRAM_WADDR = waddr;
    assign bus.SRAM_WDATA = wdata;
endmodule
